// File: rtl/updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : updown_counter
//  Description : Parametrised synchronous up/down counter with modulus,
//                parallel load (clamped to MODULUS-1), count enable with a
//                built-in prescaler, combinational terminal count and a
//                registered one-cycle wrap pulse for cascading.
//                Optional saturate mode is built when the macro
//                UPDOWN_COUNTER_SAT_EN is defined (adds the sat port).
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_counter #(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  // Largest legal count value; MODULUS may equal 2^WIDTH so MAX always fits.
  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic             w_pre_last;
  logic             w_step;
  logic             w_sat;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_boundary;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_next;
  logic             w_wrap_evt;

`ifdef UPDOWN_COUNTER_SAT_EN
  assign w_sat = sat;
`else
  assign w_sat = 1'b0;
`endif

  // Prescaler: only a real register when more than one enabled cycle per step.
  generate
    if (PRESCALE > 1) begin : g_prescale
      localparam int C_PW = $clog2(PRESCALE);
      logic [C_PW-1:0] r_pre_cnt;

      assign w_pre_last = (r_pre_cnt == C_PW'(PRESCALE - 1));

      // Phase counter: cleared by reset and load, advances only while enabled.
      always_ff @(posedge clk) begin
        if (rst || load) begin
          r_pre_cnt <= '0;
        end else if (en) begin
          if (w_pre_last) begin
            r_pre_cnt <= '0;
          end else begin
            r_pre_cnt <= r_pre_cnt + C_PW'(1);
          end
        end
      end
    end else begin : g_no_prescale
      assign w_pre_last = 1'b1;
    end
  endgenerate

  assign w_step         = en & w_pre_last;
  assign w_at_max       = (r_count == C_MAX);
  assign w_at_zero      = (r_count == '0);
  assign w_boundary     = up ? w_at_max : w_at_zero;
  assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

  // Next value for a step: wrap modulo MODULUS, or hold at the boundary in sat mode.
  always_comb begin
    w_next     = r_count;
    w_wrap_evt = 1'b0;
    if (w_boundary) begin
      if (!w_sat) begin
        w_next     = up ? '0 : C_MAX;
        w_wrap_evt = 1'b1;
      end
    end else begin
      w_next = up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
    end
  end

  // Count and wrap registers: reset beats load beats step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_count <= w_next;
      r_wrap  <= w_wrap_evt;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  // Terminal count is deliberately ungated by en so cascades can AND it in.
  assign tc    = w_boundary;

endmodule
`default_nettype wire

// File: tb/tb_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_counter
//  Description : Self-checking bench. Three counters (MOD16/P1, MOD10/P1,
//                MOD16/P3) share one stimulus stream; a reference model
//                pushes expected count/wrap into a queue per cycle, which is
//                popped and compared after each rising edge.
//                Saturate stimulus is meaningful with UPDOWN_COUNTER_SAT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic       sat = 1'b0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c;
  logic       wrap_a, wrap_b, wrap_c;

  int total = 0;
  int bad   = 0;

  int mod_p[3] = '{16, 10, 16};
  int pre_p[3] = '{1, 1, 3};
  int m_cnt[3];
  int m_pre[3];
  int m_wrap[3];

  int q_cnt[$];
  int q_wrap[$];

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .count(cnt_a), .tc(tc_a), .wrap(wrap_a));

  updown_counter #(.WIDTH(4), .MODULUS(10), .PRESCALE(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .count(cnt_b), .tc(tc_b), .wrap(wrap_b));

  updown_counter #(.WIDTH(4), .MODULUS(16), .PRESCALE(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .count(cnt_c), .tc(tc_c), .wrap(wrap_c));

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour for one instance, applied to the current inputs.
  task automatic model(input int i);
    int mx;
    bit s;
    mx = mod_p[i] - 1;
`ifdef UPDOWN_COUNTER_SAT_EN
    s = sat;
`else
    s = 1'b0;
`endif
    if (rst) begin
      m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0;
    end else if (load) begin
      m_cnt[i] = (int'(load_val) > mx) ? mx : int'(load_val);
      m_pre[i] = 0; m_wrap[i] = 0;
    end else if (en) begin
      m_wrap[i] = 0;
      if (m_pre[i] == pre_p[i] - 1) begin
        m_pre[i] = 0;
        if (up) begin
          if (m_cnt[i] == mx) begin
            if (!s) begin m_cnt[i] = 0; m_wrap[i] = 1; end
          end else m_cnt[i] = m_cnt[i] + 1;
        end else begin
          if (m_cnt[i] == 0) begin
            if (!s) begin m_cnt[i] = mx; m_wrap[i] = 1; end
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end else begin
        m_pre[i] = m_pre[i] + 1;
      end
    end else begin
      m_wrap[i] = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit ld, input int lv, input bit e,
                     input bit u, input bit s);
    int ec, ew, oc[3], ow[3], ot[3];
    @(negedge clk);
    rst = r; load = ld; load_val = 4'(lv); en = e; up = u; sat = s;
    for (int i = 0; i < 3; i++) begin
      model(i);
      q_cnt.push_back(m_cnt[i]);
      q_wrap.push_back(m_wrap[i]);
    end
    @(posedge clk);
    #1;
    oc = '{int'(cnt_a), int'(cnt_b), int'(cnt_c)};
    ow = '{int'(wrap_a), int'(wrap_b), int'(wrap_c)};
    ot = '{int'(tc_a), int'(tc_b), int'(tc_c)};
    for (int i = 0; i < 3; i++) begin
      ec = q_cnt.pop_front();
      ew = q_wrap.pop_front();
      check($sformatf("count[%0d]", i), oc[i], ec);
      check($sformatf("wrap[%0d]", i), ow[i], ew);
      check($sformatf("tc[%0d]", i), ot[i],
            up ? int'(ec == mod_p[i] - 1) : int'(ec == 0));
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_pre[i] = 0; m_wrap[i] = 0; end
    // Reset for two cycles, then count up through a full wrap.
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 17; k++) cyc(0, 0, 0, 1, 1, 0);
    // Load 3, count down across zero.
    cyc(0, 1, 3, 0, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 0, 0);
    // Clamped load.
    cyc(0, 1, 12, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    // Priority: reset over load and step, then load over step.
    cyc(1, 1, 9, 1, 1, 0);
    cyc(0, 1, 5, 1, 1, 0);
    // Prescaler with a disabled cycle in the middle.
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 1, 1, 0);
    // Mid-prescale load restarts the phase.
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 7, 1, 1, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1, 0);
    // Direction change mid-prescale.
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    // Reset asserted mid-prescale.
    cyc(0, 0, 0, 1, 1, 0);
    cyc(1, 0, 0, 1, 1, 0);
    // Saturate: hold at the top, then release and wrap; then hold at zero.
    cyc(0, 1, 14, 0, 1, 1);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1, 0, 1);
    // Random traffic.
    for (int k = 0; k < 300; k++)
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
          int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 5) != 0), ($urandom_range(0, 2) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
